alu_control_seq: RTL and testbench
==================================

Name: alu_control_seq

Overview:
- Parametrised ALU control stage that turns the pipeline-1 ALU opcode into registered ALU control lines and an ALU clock enable.
- The decode table is writable at run time.
- Each opcode can run as a multi-cycle op, holding its control word and asserting a stall upstream for a per-opcode repeat count.
- Sits between the pipeline-1 output register and the ALU datapath; replaces the fixed single-cycle decode.

Parameters:
- OP_W, 4: opcode width; table depth is 2^OP_W.
- CTRL_W, 8: control word width. Bit order is RHS0..RHS3, LHS0, LHS1, CS0, CS1 when CTRL_W=8.
- ITER_W, 3: repeat-count field width. An op occupies 1..2^ITER_W cycles.

Ports:
- Clock  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- AluOp  in  OP_W  opcode from pipeline 1; 0 = NOP
- TblWrEn  in  1  table write strobe
- TblWrAddr  in  OP_W  table entry to write
- TblWrData  in  CTRL_W+ITER_W  {iter_count, ctrl_word}
- AluCtrl  out  CTRL_W  registered control word to the ALU
- AluActive  out  1  registered; high while a non-NOP op is executing
- AluClockEn  out  1  ALU clock enable, equal to AluActive
- AluClock  out  1  ALU clock (see Optional Feature)
- AluBusy  out  1  stall to pipeline; high while the op holds beyond its first cycle

Behaviour:
- Reset (async, Reset_n low): AluCtrl=0, AluActive=0, AluClockEn=0, AluBusy=0, state=IDLE, repeat counter=0. Takes effect immediately, including mid-op; the in-flight op is abandoned.
- Table contents at reset, when OP_W=4 and CTRL_W=8. Control words for opcodes 0..15:
  - 00 NOP, 10 SHL, 20 SHR, 0C ADD, 4C ADDC, 80 INC, 40 INCC, 83 SUB
  - 43 SUBB, 0F DEC, 38 AND, 3E OR, 36 XOR, 33 NOT, 30 CLC, 00 (15)
  - All iter counts = 0.
- Table contents at reset for any other parameter set: all entries 0.
- Table write: on a rising edge with TblWrEn=1, entry[TblWrAddr] <= TblWrData. Writes are accepted in any state.
- Read-before-write: a decode and a write to the same entry in the same cycle use the old entry. The new value applies from the next decode.
- An in-flight op keeps its latched control word and count even if its entry is rewritten.
- Entry 0 is writable, but opcode 0 is always decoded as NOP: AluCtrl=0, AluActive=0, count ignored.
- State IDLE/EXEC:
  - On each rising edge with AluBusy=0, AluOp is sampled.
  - If AluOp=0: next state IDLE, AluCtrl=0, AluActive=0.
  - If AluOp!=0: next state EXEC, AluCtrl=entry.ctrl, AluActive=1, counter=entry.iter.
  - Latency: one cycle from AluOp to AluCtrl.
- State EXEC with counter>0:
  - Next state HOLD; counter decrements; AluCtrl and AluActive are held; AluBusy=1 (registered, same edge).
  - AluOp is ignored; the pipeline must hold it stable.
- State HOLD:
  - Each edge decrements the counter.
  - When the counter reaches 0, AluBusy drops on that edge. AluOp is sampled on the following edge.
- Cycle count: an op with iter=N keeps AluActive=1 for exactly N+1 cycles and AluBusy=1 for exactly N cycles.
- Back-to-back: non-NOP ops with iter=0 stream one per cycle with AluActive continuously high.
- AluClockEn always equals AluActive.
- No illegal opcodes exist. Opcode 2^OP_W-1 is an ordinary table entry.

Optional Feature:
- Macro: ALU_CTRL_CLKGATE_EN.
- Defined:
  - A negedge flop captures the next-cycle AluActive.
  - AluClock = Clock AND that flop, so the ALU clock is glitch-free and pulses only while AluActive=1.
  - The flop resets to 0.
- Undefined:
  - AluClock = Clock (ungated); the ALU must qualify with AluClockEn.
  - No negedge logic is present.

Test Plan:
- Reset then AluOp=3 for one cycle, then 0 -> next cycle AluCtrl=0x0C, AluActive=1, AluBusy=0; following cycle AluCtrl=0, AluActive=0.
- Sweep AluOp 0..15 with iter=0 -> AluCtrl matches the reset table one cycle later; AluActive=0 only for opcode 0; AluBusy never asserts.
- Write entry 1 = {iter=3, ctrl=0x10}, then AluOp=1 -> AluCtrl=0x10 and AluActive=1 for 4 cycles; AluBusy=1 for cycles 2..4. A different AluOp presented during busy is ignored, then accepted on the first non-busy edge.
- Write entry 5 in the same cycle that AluOp=5 is sampled -> old value 0x80 is output; the next AluOp=5 outputs the new value.
- Assert Reset_n=0 in the middle of an iter=7 op -> all outputs 0 immediately; table returns to defaults (AluOp=1 afterwards gives 0x10, single cycle).
- With ALU_CTRL_CLKGATE_EN: ops 3,0,7 -> AluClock pulses only in the cycles where AluActive=1, with no partial pulses. Without the macro: AluClock toggles every cycle.

Source files
------------

// File: rtl/alu_control_seq.sv
// alu_control_seq: ALU control stage with a run-time writable decode table.
// Each opcode maps to {iter_count, ctrl_word}; a non-zero iter_count holds the
// control word for iter_count extra cycles and stalls the pipeline meanwhile.
// Optional build macro: ALU_CTRL_CLKGATE_EN (glitch-free gated ALU clock).
module alu_control_seq #(
    parameter int unsigned OP_W   = 4,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned ITER_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [OP_W-1:0]          alu_op,
    input  logic                     tbl_wr_en,
    input  logic [OP_W-1:0]          tbl_wr_addr,
    input  logic [CTRL_W+ITER_W-1:0] tbl_wr_data,
    output logic [CTRL_W-1:0]        alu_ctrl,
    output logic                     alu_active,
    output logic                     alu_clock_en,
    output logic                     alu_clock,
    output logic                     alu_busy
);

    localparam int unsigned DEPTH = 2 ** OP_W;
    localparam int unsigned ENT_W = CTRL_W + ITER_W;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StHold
    } state_e;

    // Power-on decode table; only the 4-bit/8-bit configuration has a known map.
    function automatic logic [ENT_W-1:0] reset_entry(input int unsigned idx);
        logic [7:0] w;
        w = 8'h00;
        if (OP_W == 4 && CTRL_W == 8) begin
            case (idx)
                1:       w = 8'h10;  // SHL
                2:       w = 8'h20;  // SHR
                3:       w = 8'h0C;  // ADD
                4:       w = 8'h4C;  // ADDC
                5:       w = 8'h80;  // INC
                6:       w = 8'h40;  // INCC
                7:       w = 8'h83;  // SUB
                8:       w = 8'h43;  // SUBB
                9:       w = 8'h0F;  // DEC
                10:      w = 8'h38;  // AND
                11:      w = 8'h3E;  // OR
                12:      w = 8'h36;  // XOR
                13:      w = 8'h33;  // NOT
                14:      w = 8'h30;  // CLC
                default: w = 8'h00;
            endcase
        end
        return ENT_W'(w);
    endfunction

    logic [ENT_W-1:0]  tbl_q [DEPTH];
    logic [ENT_W-1:0]  rd_ent;

    state_e            state_q, state_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              active_q, active_d;
    logic              busy_q, busy_d;
    logic              sample_op;

    // Decode table storage; a same-cycle decode sees the pre-write entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= reset_entry(i);
            end
        end else if (tbl_wr_en) begin
            tbl_q[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    assign rd_ent = tbl_q[alu_op];

    // Sequencer registers; reset abandons any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            active_q <= active_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state: sample a new opcode only when the current op has no hold cycles left.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        active_d  = active_q;
        busy_d    = busy_q;
        sample_op = 1'b0;

        case (state_q)
            StExec: begin
                if (cnt_q != '0) begin
                    state_d = StHold;
                    cnt_d   = cnt_q - 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    sample_op = 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    // Op finished: release the stall; the next opcode is taken on the
                    // following edge, so the ALU sees one idle cycle in between.
                    state_d  = StIdle;
                    ctrl_d   = '0;
                    active_d = 1'b0;
                    busy_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                sample_op = 1'b1;
            end
        endcase

        if (sample_op) begin
            busy_d = 1'b0;
            if (alu_op == '0) begin
                // Opcode 0 is NOP regardless of what entry 0 holds.
                state_d  = StIdle;
                ctrl_d   = '0;
                active_d = 1'b0;
                cnt_d    = '0;
            end else begin
                state_d  = StExec;
                ctrl_d   = rd_ent[CTRL_W-1:0];
                active_d = 1'b1;
                cnt_d    = rd_ent[ENT_W-1:CTRL_W];
            end
        end
    end

    assign alu_ctrl     = ctrl_q;
    assign alu_active   = active_q;
    assign alu_clock_en = active_q;
    assign alu_busy     = busy_q;

`ifdef ALU_CTRL_CLKGATE_EN
    logic gate_q;

    // Gate enable changes only while clk is low, so the AND below cannot glitch.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q <= 1'b0;
        end else begin
            gate_q <= active_d;
        end
    end

    assign alu_clock = clk & gate_q;
`else
    assign alu_clock = clk;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: directed + random stimulus for alu_control_seq, checked
// every cycle against a schedule-queue model of the op sequencing rules.
module tb_alu_control_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  alu_op = '0;
    logic        tbl_wr_en = 1'b0;
    logic [3:0]  tbl_wr_addr = '0;
    logic [10:0] tbl_wr_data = '0;
    logic [7:0]  alu_ctrl;
    logic        alu_active;
    logic        alu_clock_en;
    logic        alu_clock;
    logic        alu_busy;

    int total = 0;
    int bad = 0;

    alu_control_seq #(
        .OP_W   (4),
        .CTRL_W (8),
        .ITER_W (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_op       (alu_op),
        .tbl_wr_en    (tbl_wr_en),
        .tbl_wr_addr  (tbl_wr_addr),
        .tbl_wr_data  (tbl_wr_data),
        .alu_ctrl     (alu_ctrl),
        .alu_active   (alu_active),
        .alu_clock_en (alu_clock_en),
        .alu_clock    (alu_clock),
        .alu_busy     (alu_busy)
    );

    always #5 clk = ~clk;

    // Expected output for one cycle.
    typedef struct packed {
        logic [7:0] ctrl;
        logic       active;
        logic       busy;
    } exp_t;

    logic [7:0]  def_ctrl [16] = '{8'h00, 8'h10, 8'h20, 8'h0C, 8'h4C, 8'h80, 8'h40, 8'h83,
                                   8'h43, 8'h0F, 8'h38, 8'h3E, 8'h36, 8'h33, 8'h30, 8'h00};
    logic [10:0] mtbl [16];
    exp_t        exp_q [$];
    exp_t        cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur = '0;
        for (int i = 0; i < 16; i++) mtbl[i] = {3'b000, def_ctrl[i]};
    endtask

    // When nothing is scheduled, the opcode is taken and its whole timeline queued:
    // N+1 active cycles (busy on all but the first), then one idle cycle if N>0.
    task automatic model_step();
        exp_t e;
        int   n;
        if (exp_q.size() == 0) begin
            if (alu_op == 4'd0) begin
                e = '0;
                exp_q.push_back(e);
            end else begin
                n = int'(mtbl[alu_op][10:8]);
                for (int i = 0; i <= n; i++) begin
                    e.ctrl   = mtbl[alu_op][7:0];
                    e.active = 1'b1;
                    e.busy   = (i > 0);
                    exp_q.push_back(e);
                end
                if (n > 0) begin
                    e = '0;
                    exp_q.push_back(e);
                end
            end
        end
        if (tbl_wr_en) mtbl[tbl_wr_addr] = tbl_wr_data;
        cur = exp_q.pop_front();
    endtask

    task automatic compare();
        check("ctrl", alu_ctrl, cur.ctrl);
        check("active", alu_active, cur.active);
        check("clk_en", alu_clock_en, cur.active);
        check("busy", alu_busy, cur.busy);
`ifdef ALU_CTRL_CLKGATE_EN
        check("alu_clock_hi", alu_clock, cur.active);
`else
        check("alu_clock_hi", alu_clock, 1);
`endif
    endtask

    // Model update on every edge, comparison 1 time unit later.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                model_step();
                #1;
                if (rst_n) compare();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input logic [7:0] c, input logic a,
                              input logic b);
        check({name, "_ctrl"}, alu_ctrl, c);
        check({name, "_active"}, alu_active, a);
        check({name, "_busy"}, alu_busy, b);
    endtask

    initial begin
        model_reset();
        repeat (2) tick();
        expect_out("reset", 8'h00, 1'b0, 1'b0);
        check("reset_clk_en", alu_clock_en, 0);
        rst_n = 1'b1;
        tick();

        // Single ADD then NOP.
        alu_op = 4'd3;
        tick();
        expect_out("add", 8'h0C, 1'b1, 1'b0);
        alu_op = 4'd0;
        tick();
        expect_out("add_after", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("alu_clock_lo", alu_clock, 0);
        tick();

        // Sweep of the power-on table.
        for (int i = 0; i < 16; i++) begin
            alu_op = 4'(i);
            tick();
            expect_out("sweep", def_ctrl[i], (i != 0), 1'b0);
        end
        alu_op = 4'd0;
        tick();

        // Multi-cycle op: entry 1 = {iter 3, ctrl 0x10}; a waiting opcode is ignored.
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = 4'd1;
        tbl_wr_data = {3'd3, 8'h10};
        tick();
        tbl_wr_en = 1'b0;
        alu_op    = 4'd1;
        tick();
        expect_out("iter_c1", 8'h10, 1'b1, 1'b0);
        alu_op = 4'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out("iter_hold", 8'h10, 1'b1, 1'b1);
        end
        tick();
        expect_out("iter_release", 8'h00, 1'b0, 1'b0);
        tick();
        expect_out("iter_next", 8'h20, 1'b1, 1'b0);
        alu_op = 4'd0;
        tick();

        // Read-before-write on entry 5.
        alu_op      = 4'd5;
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = 4'd5;
        tbl_wr_data = {3'd0, 8'hAA};
        tick();
        check("rbw_old", alu_ctrl, 8'h80);
        tbl_wr_en = 1'b0;
        tick();
        check("rbw_new", alu_ctrl, 8'hAA);
        alu_op = 4'd0;
        tick();

        // Entry 0 rewritten still decodes as NOP.
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = 4'd0;
        tbl_wr_data = {3'd2, 8'hFF};
        tick();
        tbl_wr_en = 1'b0;
        tick();
        expect_out("nop_entry0", 8'h00, 1'b0, 1'b0);
        tick();
        expect_out("nop_entry0_b", 8'h00, 1'b0, 1'b0);

        // Random opcodes and table writes, checked by the model every cycle.
        repeat (600) begin
            alu_op      = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            tbl_wr_en   = ($urandom_range(0, 4) == 0);
            tbl_wr_addr = 4'($urandom);
            tbl_wr_data = 11'($urandom);
            tick();
        end
        alu_op    = 4'd0;
        tbl_wr_en = 1'b0;
        repeat (10) tick();

        // Reset in the middle of an iter=7 op.
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = 4'd7;
        tbl_wr_data = {3'd7, 8'h55};
        tick();
        tbl_wr_en   = 1'b0;
        tbl_wr_addr = 4'd0;
        alu_op      = 4'd7;
        tick();
        expect_out("long_c1", 8'h55, 1'b1, 1'b0);
        tick();
        tick();
        expect_out("long_c3", 8'h55, 1'b1, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 8'h00, 1'b0, 1'b0);
        check("async_rst_clk_en", alu_clock_en, 0);
        tick();
        rst_n  = 1'b1;
        alu_op = 4'd1;
        tick();
        expect_out("post_rst", 8'h10, 1'b1, 1'b0);
        alu_op = 4'd0;
        tick();
        expect_out("post_rst_single", 8'h00, 1'b0, 1'b0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
